// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with MTHI/MTLO writes.
// The result is computed at launch and held in pending registers; it commits to HI/LO when the busy countdown expires.
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  op,
   input  logic        start,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q;
   logic              busy_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       hi_q, lo_q;
   logic [31:0]       pend_hi_q, pend_lo_q;
   logic              pend_wr_q;

   logic [31:0]       pend_hi_d, pend_lo_d;
   logic              pend_wr_d;
   logic              is_mul, is_div;

   logic signed [63:0] a_sx, b_sx, prod_s;
   logic        [63:0] prod_u;
   logic               div_zero, div_ovf;
   logic signed [31:0] a_sg, div_b_sg, quo_s, rem_s;
   logic        [31:0] div_b_u, quo_u, rem_u;

   assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div = (op == OP_DIV)  || (op == OP_DIVU);

   assign a_sx   = {{32{src_a[31]}}, src_a};
   assign b_sx   = {{32{src_b[31]}}, src_b};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, src_a} * {32'd0, src_b};

   // Substitute a divisor of 1 for the zero and MIN/-1 cases so the dividers never see an undefined operation.
   assign div_zero = (src_b == 32'd0);
   assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
   assign a_sg     = $signed(src_a);
   assign div_b_sg = (div_zero || div_ovf) ? 32'sd1 : $signed(src_b);
   assign quo_s    = a_sg / div_b_sg;
   assign rem_s    = a_sg % div_b_sg;
   assign div_b_u  = div_zero ? 32'd1 : src_b;
   assign quo_u    = src_a / div_b_u;
   assign rem_u    = src_a % div_b_u;

   // NOTE: every signal written here gets a default first, otherwise unlisted paths infer latches.
   always_comb begin
      pend_hi_d = '0;
      pend_lo_d = '0;
      pend_wr_d = 1'b0;
      case (op)
         OP_MULT: begin
            {pend_hi_d, pend_lo_d} = prod_s;
            pend_wr_d              = 1'b1;
         end
         OP_MULTU: begin
            {pend_hi_d, pend_lo_d} = prod_u;
            pend_wr_d              = 1'b1;
         end
         OP_DIV: begin
            pend_wr_d = !div_zero;
            if (div_ovf) begin
               pend_lo_d = 32'h8000_0000;
               pend_hi_d = 32'd0;
            end else begin
               pend_lo_d = quo_s;
               pend_hi_d = rem_s;
            end
         end
         OP_DIVU: begin
            pend_wr_d = !div_zero;
            pend_lo_d = quo_u;
            pend_hi_d = rem_u;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (op == OP_MTHI) hi_q <= src_a;
               if (op == OP_MTLO) lo_q <= src_a;
               if (start && (is_mul || is_div)) begin
                  pend_hi_q <= pend_hi_d;
                  pend_lo_q <= pend_lo_d;
                  pend_wr_q <= pend_wr_d;
                  cnt_q     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  busy_q    <= 1'b1;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               if (cnt_q <= CNT_W'(1)) begin
                  if (pend_wr_q) begin
                     hi_q <= pend_hi_q;
                     lo_q <= pend_lo_q;
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: inputs driven and outputs sampled on the falling edge.
module tb_mul_div_unit;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  op;
   logic        start;
   logic [31:0] src_a, src_b;
   logic        busy;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .op    (op),
      .start (start),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      op = OP_NOP; start = 1'b0; src_a = '0; src_b = '0;
   endtask

   task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; start = 1'b1; src_a = a; src_b = b;
      @(negedge clk);
      idle_inputs();
   endtask

   // Counts busy samples from the current cycle until busy drops, bounded.
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n_exp,
                         input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int c;
      launch(o, a, b);
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      check({tag, "_hi_during"}, 64'(hi), 64'(pre_hi));
      check({tag, "_lo_during"}, 64'(lo), 64'(pre_lo));
      wait_idle(c);
      check({tag, "_busy_len"}, 64'(c), 64'(n_exp));
      check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      int c;
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);

      // Launch on the very first edge after reset release.
      reset = 1'b1;
      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h1, 32'hFFFF_FFFE);
      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h1, 32'h3);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h1, 32'h3, 32'h0, 32'h8000_0000);

      op = OP_MTHI; src_a = 32'h1234_5678;
      @(negedge clk);
      check("mthi_hi", 64'(hi), 64'h1234_5678);
      check("mthi_busy", 64'(busy), 64'd0);
      op = OP_MTLO; src_a = 32'h9ABC_DEF0;
      @(negedge clk);
      idle_inputs();
      check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
      check("mtlo_hi_kept", 64'(hi), 64'h1234_5678);

      run_op("divu_zero", OP_DIVU, 32'h55, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0);
      run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1, 32'hFFFF_FFFD);

      // MTLO and a relaunch while busy must both be ignored.
      launch(OP_MULT, 32'd7, 32'd6);
      @(negedge clk);
      op = OP_MTLO; src_a = 32'hDEAD_BEEF;
      @(negedge clk);
      op = OP_MULT; start = 1'b1; src_a = 32'd100; src_b = 32'd100;
      @(negedge clk);
      idle_inputs();
      check("ign_lo_during", 64'(lo), 64'hFFFF_FFFD);
      wait_idle(c);
      check("ign_busy_len", 64'(3 + c), 64'd5);
      check("ign_hi", 64'(hi), 64'h0);
      check("ign_lo", 64'(lo), 64'h2A);
      @(negedge clk);
      check("ign_no_relaunch", 64'(busy), 64'd0);

      // Start with a non-launch opcode stays idle.
      op = 4'd7; start = 1'b1; src_a = 32'h1111_1111;
      @(negedge clk);
      check("bad_op_busy", 64'(busy), 64'd0);
      op = OP_NOP;
      @(negedge clk);
      idle_inputs();
      check("nop_start_busy", 64'(busy), 64'd0);
      check("bad_op_lo", 64'(lo), 64'h2A);

      // Reset mid-divide discards the in-flight result.
      launch(OP_DIV, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      check("rst_busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      repeat (12) @(negedge clk);
      check("rst_no_commit_busy", 64'(busy), 64'd0);
      check("rst_no_commit_hi", 64'(hi), 64'd0);
      check("rst_no_commit_lo", 64'(lo), 64'd0);
      run_op("mult_after_rst", OP_MULT, 32'h0001_0000, 32'h0001_0000, 5, 32'h0, 32'h0, 32'h1, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL declare parameter MULT_CYCLES, default 5, busy duration of multiply operations in cycles.
REQ-002 SHALL declare parameter DIV_CYCLES, default 10, busy duration of divide operations in cycles.
REQ-003 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 SHALL provide op  input  4  operation code: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; all other codes are no-op.
REQ-006 SHALL provide start  input  1  launch strobe for codes 1-4, driven by the execute stage.
REQ-007 SHALL provide src_a  input  32  rs operand, forwarded value.
REQ-008 SHALL provide src_b  input  32  rt operand, forwarded value.
REQ-009 SHALL provide busy  output  1  high while a multiply/divide is in flight.
REQ-010 SHALL provide hi  output  32  committed HI register.
REQ-011 SHALL provide lo  output  32  committed LO register.

Function
REQ-012 SHALL implement states IDLE and RUN, plus a down-counter of width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
REQ-013 SHALL, in IDLE on an edge with start=1 and op in 1-4, capture the result into internal pending registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 SHALL drive busy=1 in RUN and 0 in IDLE, so busy is high for exactly N cycles after the launch edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-015 SHALL decrement the counter on each RUN edge and, on the edge where it reaches 0, copy pending values to hi/lo and return to IDLE; hi/lo are visible in the first cycle with busy=0.
REQ-016 SHALL keep hi/lo unchanged during RUN; they show the pre-launch values.
REQ-017 SHALL compute MULT as a signed 64-bit product {hi,lo} and MULTU as an unsigned 64-bit product.
REQ-018 SHALL compute DIV with signed quotient truncated toward zero into lo and remainder carrying the sign of the dividend into hi; DIVU unsigned.
REQ-019 SHALL give DIV 0x80000000 / 0xFFFFFFFF the result lo=0x80000000, hi=0.
REQ-020 SHALL, on divide by zero (src_b=0), still assert busy for DIV_CYCLES and leave hi/lo unchanged at completion.
REQ-021 SHALL, in IDLE, write src_a to hi on any edge with op=5 and to lo on any edge with op=6, independent of start.
REQ-022 SHALL ignore start and ops 1-6 during RUN; no relaunch, no MTHI/MTLO write, and no change to the pending result.
REQ-023 SHALL ignore start when op is outside 1-4; the block stays in IDLE.
REQ-024 SHALL keep all outputs driven directly from registers, with no combinational path from inputs to busy/hi/lo.

Reset
REQ-025 SHALL, on a reset=0 edge, force IDLE, busy=0, counter=0, hi=0, lo=0, and pending=0.
REQ-026 SHALL give reset priority over all other inputs, including mid-RUN, where the in-flight result is discarded and never committed.
REQ-027 SHALL accept a new launch on the first edge after reset returns to 1.

Verification
REQ-028 SHALL pass: MULT src_a=0xFFFFFFFE(-2), src_b=3, start 1 cycle -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 SHALL pass: MULTU src_a=0xFFFFFFFF, src_b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 SHALL pass: DIV src_a=0xFFFFFFF9(-7), src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-031 SHALL pass: MTHI src_a=0x12345678 then MTLO src_a=0x9ABCDEF0 (busy=0) -> hi=0x12345678, lo=0x9ABCDEF0 one edge after each; DIVU x/0 afterwards -> values unchanged after 10 busy cycles.
REQ-032 SHALL pass: MULT launched, MTLO 0xDEADBEEF and a second start issued at busy cycle 2 -> both ignored; completion at cycle 5 yields the first product only.
REQ-033 SHALL pass: DIV launched, reset=0 at busy cycle 4 -> next edge busy=0, hi=lo=0; no later commit; new MULT after reset release runs normally.
